rf_wb_ctrl: RTL and testbench
=============================

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 Parameters: ADDR_WIDTH, 5, register address width; DATA_WIDTH, 32, data width; N_SRC, 3, number of writeback sources.
REQ-002 clk  input  1  sole clock, all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 iss_valid  input  1  issue stage presents an instruction.
REQ-005 iss_rd  input  ADDR_WIDTH  destination register of the issuing instruction.
REQ-006 iss_ra0, iss_ra1  input  ADDR_WIDTH  source registers of the issuing instruction.
REQ-007 iss_ready  output  1  instruction accepted this cycle when high together with iss_valid.
REQ-008 wb_valid  input  N_SRC  per-source writeback request.
REQ-009 wb_addr  input  N_SRC*ADDR_WIDTH  per-source destination; source i is at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 wb_data  input  N_SRC*DATA_WIDTH  per-source write data; same slicing rule.
REQ-011 wb_ready  output  N_SRC  one-hot grant; a source's request completes when its valid and ready are both high.
REQ-012 rf_we, rf_wa, rf_wd  output  1/ADDR_WIDTH/DATA_WIDTH  registered drive of the register file write port.
REQ-013 pend_cnt  output  ADDR_WIDTH+1  number of registers currently marked busy.

Function
REQ-014 Busy state: one bit per register; bit 0 is permanently 0.
REQ-015 clr_hit(a) is true when rf_we=1 and rf_wa=a in the current cycle; it covers the register file's same-cycle write bypass.
REQ-016 src_hazard is true when, for iss_ra0 or iss_ra1 nonzero, busy[ra] is set and clr_hit(ra) is false.
REQ-017 dst_hazard is true when iss_rd is nonzero, busy[iss_rd] is set and clr_hit(iss_rd) is false.
REQ-018 iss_ready = ~src_hazard & ~dst_hazard; it is combinational and independent of iss_valid.
REQ-019 On issue fire with iss_rd≠0: busy[iss_rd] is set at the clock edge. Issue with iss_rd=0 fires but sets nothing.
REQ-020 On each edge where rf_we=1, busy[rf_wa] is cleared.
REQ-021 When set and clear target the same register on the same edge, set wins and the bit stays 1.
REQ-022 Arbitration is round-robin over asserted wb_valid bits; the search starts at (last granted + 1) mod N_SRC.
REQ-023 At most one wb_ready bit is high per cycle, and only for a requesting source; wb_ready is combinational.
REQ-024 The last-granted pointer updates only on a grant edge.
REQ-025 Granted request in cycle N: rf_we=1, rf_wa=wb_addr[g] and rf_wd=wb_data[g] appear in cycle N+1. Latency is 1.
REQ-026 A granted request with address 0 drives rf_we=0 in cycle N+1 but still consumes the grant.
REQ-027 With no grant, rf_we=0 in the next cycle; rf_wa and rf_wd hold their last values.
REQ-028 pend_cnt tracks the busy population: +1 on set only, -1 on clear only, unchanged when both or neither occur; it never wraps.
REQ-029 Writeback to a non-busy register is legal: it is written, busy is unchanged and pend_cnt is unchanged.

Reset
REQ-030 On rst assertion, immediately and independent of clk: all busy bits 0, pend_cnt 0, rf_we 0, rf_wa 0, rf_wd 0, round-robin pointer at N_SRC-1 (so source 0 has first priority).
REQ-031 A request or issue in progress when rst asserts is discarded; nothing is replayed after release.

Structure
REQ-032 Package rf_ctrl_pkg holds N_SRC, the ADDR_WIDTH/DATA_WIDTH defaults and a localparam NREG = 1<<ADDR_WIDTH.
REQ-033 Sub-module rr_arb (parameter N) holds the round-robin pointer and produces the one-hot grant; everything else stays in rf_wb_ctrl.

Verification
REQ-034 Issue rd=5; next cycle issue with ra0=5 -> iss_ready=0. Source 1 writes r5 -> in the cycle rf_we=1, rf_wa=5, iss_ready=1; the following cycle pend_cnt=0.
REQ-035 All three sources hold valid continuously after reset -> grants in order 0,1,2,0,1,2; rf_wa follows with 1-cycle lag.
REQ-036 Edge with rf_we=1, rf_wa=7 and an issue with rd=7 -> busy[7] stays 1, pend_cnt unchanged.
REQ-037 Source 0 writes addr 0 with data 0xDEADBEEF -> wb_ready[0]=1, next cycle rf_we=0; issue with rd=0 or ra0=0 is never stalled.
REQ-038 Mark r3, r4, r9 busy (pend_cnt=3); assert rst mid-cycle -> asynchronously pend_cnt=0, rf_we=0; next request from sources 0 and 2 -> source 0 granted first.
REQ-039 Issue rd=12 while busy[12]=1 with no clear pending -> iss_ready=0 (WAW stall) until the writeback to r12 appears on rf_we.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file writeback controller and its arbiter.
// Holds the default widths, the source count and a pointer-width helper.
package rf_ctrl_pkg;

    localparam int N_SRC           = 3;
    localparam int ADDR_WIDTH_DFLT = 5;
    localparam int DATA_WIDTH_DFLT = 32;
    localparam int NREG            = 1 << ADDR_WIDTH_DFLT;

    // A single-requester arbiter still needs a one-bit pointer register.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot combinational grant, searching from the source
// after the last granted one; the pointer moves only when a grant is issued.
module rr_arb
    import rf_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = ptr_width(N);

    logic [PW-1:0] last_q;
    logic [PW-1:0] last_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt    = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_q) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                last_d   = PW'(idx);
            end
        end
    end

    // Pointer starts at the last source so that source 0 wins first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: scoreboards busy registers for issue
// hazards and arbitrates writeback sources onto a registered write port.
module rf_wb_ctrl #(
    parameter int ADDR_WIDTH = rf_ctrl_pkg::ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH = rf_ctrl_pkg::DATA_WIDTH_DFLT,
    parameter int N_SRC      = rf_ctrl_pkg::N_SRC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iss_valid,
    input  logic [ADDR_WIDTH-1:0]       iss_rd,
    input  logic [ADDR_WIDTH-1:0]       iss_ra0,
    input  logic [ADDR_WIDTH-1:0]       iss_ra1,
    output logic                        iss_ready,
    input  logic [N_SRC-1:0]            wb_valid,
    input  logic [N_SRC*ADDR_WIDTH-1:0] wb_addr,
    input  logic [N_SRC*DATA_WIDTH-1:0] wb_data,
    output logic [N_SRC-1:0]            wb_ready,
    output logic                        rf_we,
    output logic [ADDR_WIDTH-1:0]       rf_wa,
    output logic [DATA_WIDTH-1:0]       rf_wd,
    output logic [ADDR_WIDTH:0]         pend_cnt
);

    localparam int NREG_L = 1 << ADDR_WIDTH;
    localparam int CW     = ADDR_WIDTH + 1;

    logic [NREG_L-1:0]     busy_q, busy_d;
    logic [CW-1:0]         pend_cnt_q, pend_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_wa_q, rf_wa_d;
    logic [DATA_WIDTH-1:0] rf_wd_q, rf_wd_d;

    logic [N_SRC-1:0]      gnt;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  hit_ra0, hit_ra1, hit_rd;
    logic                  src_hazard, dst_hazard;
    logic                  iss_fire, set_en, set_eff, clr_eff;

    rr_arb #(.N(N_SRC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (wb_valid),
        .gnt (gnt)
    );

    // A write landing this cycle already satisfies the hazard via the RF bypass.
    assign hit_ra0 = rf_we_q && (rf_wa_q == iss_ra0);
    assign hit_ra1 = rf_we_q && (rf_wa_q == iss_ra1);
    assign hit_rd  = rf_we_q && (rf_wa_q == iss_rd);

    assign src_hazard = ((iss_ra0 != '0) && busy_q[iss_ra0] && !hit_ra0) ||
                        ((iss_ra1 != '0) && busy_q[iss_ra1] && !hit_ra1);
    assign dst_hazard = (iss_rd != '0) && busy_q[iss_rd] && !hit_rd;

    assign iss_ready = !src_hazard && !dst_hazard;
    assign iss_fire  = iss_valid && iss_ready;
    assign set_en    = iss_fire && (iss_rd != '0);

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                g_addr = wb_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_data = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The count follows real 0->1 and 1->0 transitions, so a same-register
    // set+clear or a write to an idle register leaves it untouched.
    always_comb begin
        busy_d     = busy_q;
        pend_cnt_d = pend_cnt_q;
        set_eff    = set_en && !busy_q[iss_rd];
        clr_eff    = rf_we_q && busy_q[rf_wa_q] && !(set_en && (iss_rd == rf_wa_q));

        if (rf_we_q) begin
            busy_d[rf_wa_q] = 1'b0;
        end
        if (set_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (set_eff && !clr_eff) begin
            pend_cnt_d = pend_cnt_q + CW'(1);
        end else if (clr_eff && !set_eff) begin
            pend_cnt_d = pend_cnt_q - CW'(1);
        end
    end

    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (|gnt) begin
            rf_we_d = (g_addr != '0);
            rf_wa_d = g_addr;
            rf_wd_d = g_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_wa_q    <= '0;
            rf_wd_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_wa_q    <= rf_wa_d;
            rf_wd_q    <= rf_wd_d;
        end
    end

    assign wb_ready = gnt;
    assign rf_we    = rf_we_q;
    assign rf_wa    = rf_wa_q;
    assign rf_wd    = rf_wd_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: issue/hazard checks inline, register-file
// writes checked by a scoreboard monitor against hand-computed expectations.
module tb_rf_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd, iss_ra0, iss_ra1;
    logic        iss_ready;
    logic [2:0]  wb_valid;
    logic [14:0] wb_addr;
    logic [95:0] wb_data;
    logic [2:0]  wb_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [5:0]  pend_cnt;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    rf_wb_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_SRC(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ra0   (iss_ra0),
        .iss_ra1   (iss_ra1),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pend_cnt  (pend_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual=running required=done)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [4:0] rd, input logic [4:0] ra0,
                                 input logic [4:0] ra1, input logic [2:0] wv);
        iss_valid = iv;
        iss_rd    = rd;
        iss_ra0   = ra0;
        iss_ra1   = ra1;
        wb_valid  = wv;
    endtask

    task automatic setSource(input int i, input logic [4:0] a, input logic [31:0] d);
        wb_addr[i*5 +: 5]  = a;
        wb_data[i*32 +: 32] = d;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle, checked before any further clock edge.
    task automatic pulseReset();
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pend", 64'(pend_cnt), 64'd0);
        checkOutput("async_rst_we", 64'(rf_we), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every register-file write must match the next expectation.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL wb_write: actual=%0d/0x%0h required=no write at %0t", rf_wa, rf_wd, $time);
            end else begin
                checkOutput("wb_write", 64'({rf_wa, rf_wd}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1;
        wb_addr = '0;
        wb_data = '0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
        #2;
        checkOutput("reset_pend", 64'(pend_cnt), 64'd0);
        checkOutput("reset_we", 64'(rf_we), 64'd0);
        checkOutput("reset_wa", 64'(rf_wa), 64'd0);
        checkOutput("reset_wd", 64'(rf_wd), 64'd0);
        checkOutput("reset_wb_ready", 64'(wb_ready), 64'd0);
        checkOutput("reset_iss_ready", 64'(iss_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RAW stall on r5, released by source 1 writing r5 via the bypass
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("raw_issue_ready", 64'(iss_ready), 64'd1);
        step(); applyStimulus(1'b1, 5'd6, 5'd5, 5'd0, 3'b000);
        #2; checkOutput("raw_stall", 64'(iss_ready), 64'd0);
        checkOutput("raw_pend1", 64'(pend_cnt), 64'd1);
        step(); setSource(1, 5'd5, 32'h1111_0005); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b010);
        #2; checkOutput("raw_grant", 64'(wb_ready), 64'b010);
        expectWrite(5'd5, 32'h1111_0005);
        step(); applyStimulus(1'b0, 5'd0, 5'd5, 5'd0, 3'b000);
        #2; checkOutput("raw_bypass_ready", 64'(iss_ready), 64'd1);
        checkOutput("raw_we", 64'(rf_we), 64'd1);
        checkOutput("raw_wa", 64'(rf_wa), 64'd5);
        step();
        #2; checkOutput("raw_pend0", 64'(pend_cnt), 64'd0);
        checkOutput("raw_we_off", 64'(rf_we), 64'd0);

        // Round-robin over three always-valid sources after reset
        pulseReset();
        setSource(0, 5'd1, 32'hA000_0001);
        setSource(1, 5'd2, 32'hA000_0002);
        setSource(2, 5'd3, 32'hA000_0003);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b111);
        for (int k = 0; k < 6; k++) begin
            #2;
            checkOutput("rr_grant", 64'(wb_ready), 64'(3'b001 << (k % 3)));
            expectWrite(5'(k % 3 + 1), 32'hA000_0000 | 32'(k % 3 + 1));
            step();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("rr_pend_idle_regs", 64'(pend_cnt), 64'd0);

        // Set and clear of r7 on the same edge: bit stays busy, count unchanged
        step(); applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("sc_issue_ready", 64'(iss_ready), 64'd1);
        step(); setSource(0, 5'd7, 32'h7777_0000); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b001);
        #2; checkOutput("sc_grant", 64'(wb_ready), 64'b001);
        checkOutput("sc_pend1", 64'(pend_cnt), 64'd1);
        expectWrite(5'd7, 32'h7777_0000);
        step(); applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("sc_waw_bypass", 64'(iss_ready), 64'd1);
        step(); applyStimulus(1'b0, 5'd0, 5'd7, 5'd0, 3'b000);
        #2; checkOutput("sc_pend_kept", 64'(pend_cnt), 64'd1);
        checkOutput("sc_still_busy", 64'(iss_ready), 64'd0);
        step(); setSource(1, 5'd7, 32'h7777_0001); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b010);
        #2; checkOutput("sc_grant2", 64'(wb_ready), 64'b010);
        expectWrite(5'd7, 32'h7777_0001);
        step(); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
        step();
        #2; checkOutput("sc_pend0", 64'(pend_cnt), 64'd0);

        // Writeback to r0 consumes the grant but never writes; r0 never stalls
        step(); setSource(0, 5'd0, 32'hDEAD_BEEF); applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 3'b001);
        #2; checkOutput("r0_grant", 64'(wb_ready), 64'b001);
        checkOutput("r0_issue_ready", 64'(iss_ready), 64'd1);
        step(); applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("r0_no_we", 64'(rf_we), 64'd0);
        checkOutput("r0_issue_ready2", 64'(iss_ready), 64'd1);
        step(); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("r0_pend", 64'(pend_cnt), 64'd0);

        // Three busy registers, then reset mid-cycle with requests in flight
        step(); applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 3'b000);
        step(); applyStimulus(1'b1, 5'd4, 5'd0, 5'd0, 3'b000);
        step(); setSource(1, 5'd20, 32'h2020_2020); applyStimulus(1'b1, 5'd9, 5'd0, 5'd0, 3'b010);
        step(); setSource(0, 5'd10, 32'h1010_0010); setSource(2, 5'd11, 32'h1111_0011);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b101);
        #2; checkOutput("pre_rst_pend3", 64'(pend_cnt), 64'd3);
        checkOutput("pre_rst_we", 64'(rf_we), 64'd1);
        pulseReset();
        #2; checkOutput("post_rst_grant0", 64'(wb_ready), 64'b001);
        expectWrite(5'd10, 32'h1010_0010);
        step();
        #2; checkOutput("post_rst_grant2", 64'(wb_ready), 64'b100);
        expectWrite(5'd11, 32'h1111_0011);
        step(); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("post_rst_pend", 64'(pend_cnt), 64'd0);

        // WAW stall on r12 until its writeback reaches the write port
        step(); applyStimulus(1'b1, 5'd12, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("waw_first_ready", 64'(iss_ready), 64'd1);
        step();
        #2; checkOutput("waw_stall", 64'(iss_ready), 64'd0);
        checkOutput("waw_pend1", 64'(pend_cnt), 64'd1);
        step(); setSource(1, 5'd12, 32'hC0DE_0012); applyStimulus(1'b1, 5'd12, 5'd0, 5'd0, 3'b010);
        #2; checkOutput("waw_stall_grant_cycle", 64'(iss_ready), 64'd0);
        checkOutput("waw_grant", 64'(wb_ready), 64'b010);
        expectWrite(5'd12, 32'hC0DE_0012);
        step(); applyStimulus(1'b1, 5'd12, 5'd0, 5'd0, 3'b000);
        #2; checkOutput("waw_release", 64'(iss_ready), 64'd1);
        checkOutput("waw_we", 64'(rf_we), 64'd1);
        step(); applyStimulus(1'b0, 5'd0, 5'd12, 5'd0, 3'b000);
        #2; checkOutput("waw_pend_kept", 64'(pend_cnt), 64'd1);
        checkOutput("waw_rebusy", 64'(iss_ready), 64'd0);
        step(); setSource(0, 5'd12, 32'hC0DE_1212); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b001);
        #2; checkOutput("waw_grant_last", 64'(wb_ready), 64'b001);
        expectWrite(5'd12, 32'hC0DE_1212);
        step(); applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
        step();
        #2; checkOutput("waw_pend0", 64'(pend_cnt), 64'd0);

        step();
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
